// File: rtl/lcm_calc_pkg.sv
// Shared types and widths for the LCM calculator.
// Optional GCD output port is enabled by defining LCM_CALC_GCD_OUT_EN.
package lcm_calc_pkg;
    localparam int OPW       = 8;
    localparam int RESW      = 16;
    localparam int MUL_STEPS = 8;

    typedef enum logic [2:0] {
        IDLE,
        GCD,
        DIV,
        MUL,
        FIN
    } state_t;
endpackage

// File: rtl/lcm_euclid_step.sv
// One subtractive Euclid iteration: subtract the smaller operand from the larger,
// and flag equality (which means the GCD has been found).
module lcm_euclid_step
    import lcm_calc_pkg::*;
(
    input  logic [OPW-1:0] i_x,
    input  logic [OPW-1:0] i_y,
    output logic           o_eq,
    output logic [OPW-1:0] o_x,
    output logic [OPW-1:0] o_y
);
    always_comb begin
        o_eq = (i_x == i_y);
        o_x  = i_x;
        o_y  = i_y;
        if (i_x > i_y)
            o_x = i_x - i_y;
        else if (i_y > i_x)
            o_y = i_y - i_x;
    end
endmodule

// File: rtl/lcm_calc.sv
// LCM of two 8-bit operands: subtractive GCD, repeated-subtraction A/g, shift-add q*B.
// Define LCM_CALC_GCD_OUT_EN to expose the GCD on output G.
module lcm_calc
    import lcm_calc_pkg::*;
(
    input  logic            CLK,
    input  logic            RST_N,
    input  logic            START,
    input  logic [OPW-1:0]  A,
    input  logic [OPW-1:0]  B,
    output logic [RESW-1:0] Y,
    output logic            DONE,
`ifdef LCM_CALC_GCD_OUT_EN
    output logic [OPW-1:0]  G,
`endif
    output logic            ERROR
);
    state_t          r_state, w_state_nxt;
    logic [OPW-1:0]  r_gx, r_gy, r_g, r_b, r_r, r_q, r_mplier;
    logic [RESW-1:0] r_mcand, r_acc, r_res;
    logic [2:0]      r_cnt;
    logic            r_err;
`ifdef LCM_CALC_GCD_OUT_EN
    logic [OPW-1:0]  r_gout;
`endif

    logic            w_eq;
    logic [OPW-1:0]  w_gx_nxt, w_gy_nxt, w_rem;
    logic [RESW-1:0] w_acc_nxt;
    logic            w_zero_op;

    lcm_euclid_step u_step (
        .i_x  (r_gx),
        .i_y  (r_gy),
        .o_eq (w_eq),
        .o_x  (w_gx_nxt),
        .o_y  (w_gy_nxt)
    );

    assign w_rem     = r_r - r_g;
    assign w_acc_nxt = r_mplier[0] ? (r_acc + r_mcand) : r_acc;
    assign w_zero_op = (A == '0) || (B == '0);

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: if (START) w_state_nxt = w_zero_op ? FIN : GCD;
            GCD:  if (w_eq) w_state_nxt = DIV;
            DIV:  if (w_rem == '0) w_state_nxt = MUL;
            MUL:  if (r_cnt == 3'(MUL_STEPS - 1)) w_state_nxt = FIN;
            FIN:  w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RST_N)
            r_state <= IDLE;
        else
            r_state <= w_state_nxt;
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            r_gx     <= '0;
            r_gy     <= '0;
            r_g      <= '0;
            r_b      <= '0;
            r_r      <= '0;
            r_q      <= '0;
            r_mplier <= '0;
            r_mcand  <= '0;
            r_acc    <= '0;
            r_cnt    <= '0;
            r_res    <= '0;
            r_err    <= 1'b0;
`ifdef LCM_CALC_GCD_OUT_EN
            r_gout   <= '0;
`endif
        end else begin
            case (r_state)
                IDLE: if (START) begin
                    r_gx  <= A;
                    r_gy  <= B;
                    r_r   <= A;
                    r_q   <= '0;
                    r_b   <= B;
                    r_res <= '0;
                    r_err <= w_zero_op;
`ifdef LCM_CALC_GCD_OUT_EN
                    r_gout <= '0;
`endif
                end
                GCD: begin
                    if (w_eq)
                        r_g <= r_gx;
                    else begin
                        r_gx <= w_gx_nxt;
                        r_gy <= w_gy_nxt;
                    end
                end
                DIV: begin
                    r_r <= w_rem;
                    r_q <= r_q + 1'b1;
                    // Final quotient is q+1 on the exit cycle; seed the multiplier with it.
                    if (w_rem == '0) begin
                        r_mplier <= r_q + 1'b1;
                        r_mcand  <= {{(RESW-OPW){1'b0}}, r_b};
                        r_acc    <= '0;
                        r_cnt    <= '0;
                    end
                end
                MUL: begin
                    r_acc    <= w_acc_nxt;
                    r_mcand  <= r_mcand << 1;
                    r_mplier <= r_mplier >> 1;
                    r_cnt    <= r_cnt + 1'b1;
                    if (r_cnt == 3'(MUL_STEPS - 1)) begin
                        r_res <= w_acc_nxt;
`ifdef LCM_CALC_GCD_OUT_EN
                        r_gout <= r_g;
`endif
                    end
                end
                default: ;
            endcase
        end
    end

    assign Y     = r_res;
    assign ERROR = r_err;
    assign DONE  = (r_state == FIN);
`ifdef LCM_CALC_GCD_OUT_EN
    assign G     = r_gout;
`endif
endmodule
